// File: rtl/pool_map_buffer.sv
// Ping-pong feature-map buffer: captures one pooled pixel per strobe and serves whole maps over valid/ready.
// First pixel valid one cycle after the map's final write; out_ready low stalls with data held; input dropped when both banks full.
module pool_map_buffer #(
  parameter int OP    = 8,
  parameter int MAP_W = 14,
  parameter int MAP_H = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [OP:0]   pxl_in,
  input  logic                 pxl_valid,
  output logic signed [OP:0]   out_pxl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int N  = MAP_W * MAP_H;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  logic signed [OP:0] mem [2][N];

  state_t          state, state_nxt;
  logic [1:0]      bank_full;
  logic            wr_bank, rd_bank;
  logic [AW-1:0]   wr_addr, rd_addr;

  logic            wr_en, wr_wrap, rd_take, rd_wrap;
  logic [1:0]      set_mask, clr_mask;

  always_comb begin
    wr_en    = pxl_valid && !bank_full[wr_bank];
    wr_wrap  = wr_en && (wr_addr == LAST_ADDR);
    rd_take  = (state == STREAM) && out_ready;
    rd_wrap  = rd_take && (rd_addr == LAST_ADDR);
    set_mask = wr_wrap ? (2'b01 << wr_bank) : 2'b00;
    clr_mask = rd_wrap ? (2'b01 << rd_bank) : 2'b00;
  end

  // Set and clear always hit different banks: a bank being written is never full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_full  <= 2'b00;
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      bank_full  <= (bank_full | set_mask) & ~clr_mask;
      frame_done <= rd_wrap;
      if (pxl_valid && bank_full[wr_bank])
        overflow <= 1'b1;
      if (wr_en) begin
        if (wr_wrap) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (rd_take) begin
        if (rd_wrap) begin
          rd_addr <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_bank][wr_addr] <= pxl_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bank_full[rd_bank]) state_nxt = STREAM;
      STREAM:  if (rd_wrap)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == STREAM);
    out_last  = out_valid && (rd_addr == LAST_ADDR);
    out_pxl   = out_valid ? mem[rd_bank][rd_addr] : '0;
  end

endmodule

// File: tb/tb_pool_map_buffer.sv
// Randomized bench for pool_map_buffer: a queue-based map model tracks capacity, ordering, drops and frame pulses.
module tb_pool_map_buffer;

  localparam int N = 196;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [8:0] pxl_in;
  logic              pxl_valid;
  logic signed [8:0] out_pxl;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              frame_done;
  logic              overflow;

  always #5 clk = ~clk;

  pool_map_buffer #(.OP(8), .MAP_W(14), .MAP_H(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .pxl_in     (pxl_in),
    .pxl_valid  (pxl_valid),
    .out_pxl    (out_pxl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  int vecs = 0;
  int errs = 0;
  int tcnt = 0;

  task automatic check(string tag, int got, int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: maps become visible as whole units; at most two complete maps held.
  logic signed [8:0] exp_q[$];
  logic signed [8:0] part_q[$];
  int full_maps = 0;
  int rcnt = 0;
  bit fd_exp = 0;
  bit ovf_exp = 0;

  always @(negedge clk) begin : mon
    bit take;
    if (!reset) begin
      exp_q.delete();
      part_q.delete();
      full_maps = 0;
      rcnt      = 0;
      fd_exp    = 0;
      ovf_exp   = 0;
    end else begin
      check("frame_done", frame_done, fd_exp);
      check("overflow", overflow, ovf_exp);
      fd_exp = 0;
      take   = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", out_valid, 0);
        end else begin
          check("out_pxl", int'(out_pxl), int'(exp_q[0]));
          check("out_last", out_last, int'(rcnt == N - 1));
          take = out_ready;
        end
      end else begin
        check("out_last_idle", out_last, 0);
      end
      if (pxl_valid) begin
        if (full_maps == 2) begin
          ovf_exp = 1;
        end else begin
          part_q.push_back(pxl_in);
          if (part_q.size() == N) begin
            exp_q = {exp_q, part_q};
            part_q.delete();
            full_maps++;
          end
        end
      end
      if (take) begin
        void'(exp_q.pop_front());
        rcnt++;
        if (rcnt == N) begin
          rcnt = 0;
          full_maps--;
          fd_exp = 1;
        end
      end
    end
  end

  function automatic bit rdy_of(int mode);
    case (mode)
      0:       return 1'b1;
      1:       return tcnt[0];
      2:       return 1'b0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic drive(bit pv, logic signed [8:0] px, bit rdy);
    @(posedge clk);
    #1;
    pxl_valid = pv;
    pxl_in    = px;
    out_ready = rdy;
    tcnt++;
  endtask

  // kind 0: ramp 0..195, 1: random, 2: extremes in first four slots then random
  task automatic send_map(int kind, int rmode, bit gaps);
    logic signed [8:0] px;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       px = 9'(i);
        1:       px = 9'($urandom);
        default: begin
          case (i)
            0:       px = -9'sd256;
            1:       px = 9'sd255;
            2:       px = -9'sd1;
            3:       px = 9'sd0;
            default: px = 9'($urandom);
          endcase
        end
      endcase
      if (gaps)
        repeat ($urandom_range(1, 5)) drive(1'b0, 9'($urandom), rdy_of(rmode));
      drive(1'b1, px, rdy_of(rmode));
    end
  endtask

  task automatic drain(int rmode);
    int budget = 3000;
    while ((exp_q.size() != 0 || full_maps != 0) && budget > 0) begin
      drive(1'b0, 9'd0, rdy_of(rmode));
      budget--;
    end
    check("drain_done", exp_q.size(), 0);
    drive(1'b0, 9'd0, 1'b1);
    drive(1'b0, 9'd0, 1'b1);
  endtask

  initial begin
    reset     = 1'b0;
    pxl_valid = 1'b0;
    pxl_in    = '0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pxl", int'(out_pxl), 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Ramp map, always ready; first valid exactly one cycle after final write
    send_map(0, 0, 1'b0);
    drive(1'b0, 9'd0, 1'b1);
    check("lat_idle", out_valid, 0);
    drive(1'b0, 9'd0, 1'b1);
    check("lat_first_valid", out_valid, 1);
    check("lat_first_pxl", int'(out_pxl), 0);
    drain(0);

    // Toggling ready
    send_map(0, 1, 1'b0);
    drain(1);

    // Extreme values, random ready
    send_map(2, 3, 1'b0);
    drain(3);

    // Gapped strobes
    send_map(0, 0, 1'b1);
    drain(0);

    // Two maps held, third map's first pixel dropped
    send_map(1, 2, 1'b0);
    send_map(1, 2, 1'b0);
    drive(1'b1, 9'sd123, 1'b0);
    drive(1'b0, 9'd0, 1'b0);
    check("overflow_set", overflow, 1);
    check("hold_valid", out_valid, 1);
    drain(0);
    check("overflow_sticky", overflow, 1);

    // Reset mid-frame with one map stalled and 100 pixels of the next written
    send_map(1, 2, 1'b0);
    for (int i = 0; i < 100; i++) drive(1'b1, 9'($urandom), 1'b0);
    drive(1'b0, 9'd0, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_pxl", int'(out_pxl), 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_overflow", overflow, 0);
    drive(1'b0, 9'd0, 1'b1);
    drive(1'b0, 9'd0, 1'b1);
    reset = 1'b1;
    send_map(0, 0, 1'b0);
    drain(0);

    // Random mixed traffic
    for (int m = 0; m < 2; m++) begin
      send_map(1, 3, 1'($urandom_range(0, 1)));
      drain(3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
